oled_pattern_gen: RTL and testbench
===================================

OLED_PATTERN_GEN -- requirements
Module: oled_pattern_gen

Interface
REQ-001 SHALL have parameter X_BITS, default 7, meaning pixel x coordinate width; legal range 6 to 10.
REQ-002 SHALL have parameter Y_BITS, default 8, meaning pixel y coordinate width; legal range 5 to 10.
REQ-003 SHALL have parameter CELL_LOG2, default 3, meaning checker cell edge is 2^CELL_LOG2 pixels; legal range 0 to min(X_BITS,Y_BITS)-1.
REQ-004 SHALL have parameter COLOR_A, default 16'hF800, meaning RGB565 colour of checker cells where the cell-parity XOR is 0.
REQ-005 SHALL have parameter COLOR_B, default 16'h07E0, meaning RGB565 colour of checker cells where the cell-parity XOR is 1.
REQ-006 SHALL have parameter SCROLL_DIV, default 1, meaning frames per scroll step; legal range 1 to 255.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port x, input, X_BITS, pixel column requested by the display driver.
REQ-010 SHALL have port y, input, Y_BITS, pixel row requested by the display driver.
REQ-011 SHALL have port mode_sel, input, 2, requested pattern mode.
REQ-012 SHALL have port color, output, 16, RGB565 pixel colour for the registered (x,y).
REQ-013 SHALL have port frame_tick, output, 1, one-cycle pulse at frame start.
REQ-014 SHALL have port mode_active, output, 2, mode currently rendered.
REQ-015 SHALL have port frame_count, output, 8, frames since reset, wrapping 255 to 0.

Function
REQ-016 SHALL register x and y every cycle into x_q and y_q; frame_tick SHALL be 1 in the cycle after (x,y) becomes (0,0) when (x_q,y_q) was not (0,0), and 0 otherwise.
REQ-017 SHALL sample mode_sel into mode_active only in cycles where frame_tick is 1; a mode_sel change in the same cycle as frame_tick takes effect on that tick.
REQ-018 SHALL increment frame_count on each frame_tick, wrapping from 255 to 0.
REQ-019 SHALL drive color from a register, so color for (x,y) is valid 1 cycle after (x,y) is applied, using the mode_active value in effect in that cycle.
REQ-020 Mode 0 (checker) SHALL output COLOR_B when x[CELL_LOG2]^y[CELL_LOG2]=1 and COLOR_A otherwise.
REQ-021 Mode 1 (bars) SHALL use b = x[X_BITS-1 -: 3] and output red 5'h1F if b[2] else 0, green 6'h3F if b[1] else 0, blue 5'h1F if b[0] else 0.
REQ-022 Mode 2 (gradient) SHALL output {y[Y_BITS-1 -: 5], x[X_BITS-1 -: 6], 5'd0}.
REQ-023 Mode 3 (scroll) SHALL output the mode 0 pattern with xs = (x + offset) truncated to X_BITS in place of x.
REQ-024 offset SHALL be an 8-bit register, zero-extended or truncated to X_BITS for the addition.
REQ-025 offset SHALL step by 1 on every SCROLL_DIV-th frame_tick while mode_active is 3, wrapping from 255 to 0.
REQ-026 A divider counter SHALL count frame_ticks from 0 to SCROLL_DIV-1 and generate the offset step when it wraps.
REQ-027 offset and the divider counter SHALL clear to 0 on any frame_tick that changes mode_active.
REQ-028 When the same (x,y) is held for multiple cycles, color SHALL remain stable, and frame_tick SHALL fire at most once per entry into (0,0).

Reset
REQ-029 While reset=1, on the next clock edge color SHALL be COLOR_A, frame_tick 0, mode_active 0, frame_count 0, offset 0, divider 0.
REQ-030 x_q and y_q SHALL reset to all-ones, so (0,0) presented immediately after reset produces one frame_tick.
REQ-031 Reset asserted mid-frame SHALL override all pending updates in that cycle.

Configuration
REQ-032 With macro OLED_PATTERN_SCROLL_EN defined, mode 3 SHALL behave as REQ-023 to REQ-027.
REQ-033 Without OLED_PATTERN_SCROLL_EN, the offset and divider logic SHALL be absent and mode 3 SHALL render identically to mode 0; mode_active SHALL still report 3.

Verification
REQ-034 Reset, mode_sel=0, (x,y)=(8,0) -> color=16'h07E0 one cycle later; (x,y)=(8,8) -> color=16'hF800.
REQ-035 Scan (127,159) then (0,0) -> frame_tick=1 for exactly one cycle and frame_count 0 to 1; holding (0,0) 5 cycles -> no further tick.
REQ-036 mode_sel changed to 1 mid-frame -> mode_active stays 0 until the next frame_tick, then 1; in mode 1, x=96 (b=6) -> color=16'hFFE0.
REQ-037 Mode 2, (x,y)=(127,159) -> color={5'd19,6'd63,5'd0}=16'h9FE0.
REQ-038 OLED_PATTERN_SCROLL_EN defined, SCROLL_DIV=2, mode 3, 8 frames -> offset=4; (x,y)=(4,0) -> color=16'h07E0 since (4+4)[3]=1; switching to mode 0 -> offset=0.
REQ-039 256 frames -> frame_count wraps to 0; reset asserted mid-scan -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/oled_pattern_gen.sv
// oled_pattern_gen -- RGB565 test-pattern source for an OLED display driver.
//
// The driver presents a pixel coordinate (x,y) each cycle; one cycle later
// color holds the pattern colour for that pixel. A frame starts whenever the
// coordinate enters (0,0); the cycle after that frame_tick pulses, and at the
// end of the tick cycle the mode, frame counter and scroll state update.
//
// Modes: 0 checker, 1 colour bars, 2 gradient, 3 scrolling checker.
// Optional feature macro: OLED_PATTERN_SCROLL_EN. When undefined, the scroll
// offset/divider are not built and mode 3 renders the plain checker.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   x, y         requested pixel column / row
//   mode_sel     requested pattern mode (adopted on frame_tick)
//   color        registered RGB565 colour for the previous cycle's (x,y)
//   frame_tick   one-cycle pulse at frame start
//   mode_active  mode currently rendered
//   frame_count  frames since reset, wraps 255 -> 0
module oled_pattern_gen #(
  parameter int          X_BITS     = 7,
  parameter int          Y_BITS     = 8,
  parameter int          CELL_LOG2  = 3,
  parameter logic [15:0] COLOR_A    = 16'hF800,
  parameter logic [15:0] COLOR_B    = 16'h07E0,
  parameter int          SCROLL_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [X_BITS-1:0] x,
  input  logic [Y_BITS-1:0] y,
  input  logic [1:0]        mode_sel,
  output logic [15:0]       color,
  output logic              frame_tick,
  output logic [1:0]        mode_active,
  output logic [7:0]        frame_count
);

  logic [X_BITS-1:0] x_q;
  logic [Y_BITS-1:0] y_q;
  logic              tick_next;
  logic [X_BITS-1:0] xs;
  logic [15:0]       color_next;
  logic [2:0]        bar;

  // Edge-detect entry into the origin so a held (0,0) ticks only once.
  assign tick_next = (x == '0) && (y == '0) && !((x_q == '0) && (y_q == '0));

`ifdef OLED_PATTERN_SCROLL_EN
  logic [7:0] offset;
  logic [7:0] div_cnt;
  logic       mode_chg;

  assign mode_chg = frame_tick && (mode_sel != mode_active);
  assign xs       = x + X_BITS'(offset);

  always_ff @(posedge clk) begin
    if (reset) begin
      offset  <= '0;
      div_cnt <= '0;
    end else if (mode_chg) begin
      offset  <= '0;
      div_cnt <= '0;
    end else if (frame_tick && (mode_active == 2'd3)) begin
      if (div_cnt == 8'(SCROLL_DIV - 1)) begin
        div_cnt <= '0;
        offset  <= offset + 8'd1;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end
`else
  assign xs = x;
`endif

  assign bar = x[X_BITS-1 -: 3];

  always_comb begin
    color_next = COLOR_A;
    case (mode_active)
      2'd0: color_next = (x[CELL_LOG2] ^ y[CELL_LOG2]) ? COLOR_B : COLOR_A;
      2'd1: color_next = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
      2'd2: color_next = {y[Y_BITS-1 -: 5], x[X_BITS-1 -: 6], 5'd0};
      2'd3: color_next = (xs[CELL_LOG2] ^ y[CELL_LOG2]) ? COLOR_B : COLOR_A;
      default: color_next = COLOR_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // All-ones so an immediate (0,0) after reset starts a frame.
      x_q         <= '1;
      y_q         <= '1;
      frame_tick  <= 1'b0;
      mode_active <= 2'd0;
      frame_count <= 8'd0;
      color       <= COLOR_A;
    end else begin
      x_q        <= x;
      y_q        <= y;
      frame_tick <= tick_next;
      color      <= color_next;
      if (frame_tick) begin
        mode_active <= mode_sel;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_oled_pattern_gen.sv
// Scoreboard bench for oled_pattern_gen: a driver applies directed and
// random pixel streams and pushes the expected outputs; a monitor pops and
// compares one entry per cycle.
module tb_oled_pattern_gen;
  localparam int          XB = 7;
  localparam int          YB = 8;
  localparam int          CL = 3;
  localparam int          SD = 2;
  localparam logic [15:0] CA = 16'hF800;
  localparam logic [15:0] CB = 16'h07E0;

  logic          clk = 1'b0;
  logic          reset;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic [1:0]    mode_sel;
  logic [15:0]   color;
  logic          frame_tick;
  logic [1:0]    mode_active;
  logic [7:0]    frame_count;

  oled_pattern_gen #(
    .X_BITS(XB), .Y_BITS(YB), .CELL_LOG2(CL),
    .COLOR_A(CA), .COLOR_B(CB), .SCROLL_DIV(SD)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .mode_sel(mode_sel),
    .color(color), .frame_tick(frame_tick), .mode_active(mode_active),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int color;
    int tick;
    int mode;
    int fc;
  } exp_t;
  exp_t sbq[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (plain integers, frame-level view).
  int m_px, m_py, m_tick, m_mode, m_fc, m_off, m_div;

  function automatic int checker_col(int xi, int yi);
    return ((((xi >> CL) ^ (yi >> CL)) & 1) != 0) ? int'(CB) : int'(CA);
  endfunction

  function automatic int pattern(int mode, int xi, int yi, int off);
    int b;
    int xs;
    case (mode)
      0: return checker_col(xi, yi);
      1: begin
        b = xi >> (XB - 3);
        return (((b >> 2) & 1) * 16'hF800) + (((b >> 1) & 1) * 16'h07E0) + ((b & 1) * 16'h001F);
      end
      2: return ((yi >> (YB - 5)) << 11) + ((xi >> (XB - 6)) << 5);
      default: begin
`ifdef OLED_PATTERN_SCROLL_EN
        xs = (xi + off) % (1 << XB);
`else
        xs = xi + 0 * off;
`endif
        return checker_col(xs, yi);
      end
    endcase
  endfunction

  task automatic step(input bit r, input int xi, input int yi, input int ms);
    exp_t e;
    bit   nt;
    @(negedge clk);
    reset    = r;
    x        = XB'(xi);
    y        = YB'(yi);
    mode_sel = 2'(ms);
    if (r) begin
      e = '{int'(CA), 0, 0, 0};
      m_px = (1 << XB) - 1; m_py = (1 << YB) - 1;
      m_tick = 0; m_mode = 0; m_fc = 0; m_off = 0; m_div = 0;
    end else begin
      e.color = pattern(m_mode, xi, yi, m_off);
      nt = (xi == 0) && (yi == 0) && !((m_px == 0) && (m_py == 0));
      if (m_tick != 0) begin
        if (ms != m_mode) begin
          m_off = 0; m_div = 0;
        end else if (m_mode == 3) begin
          m_div = m_div + 1;
          if (m_div == SD) begin
            m_div = 0;
            m_off = (m_off + 1) % 256;
          end
        end
        m_mode = ms;
        m_fc   = (m_fc + 1) % 256;
      end
      m_tick = nt;
      m_px = xi; m_py = yi;
      e.tick = m_tick; e.mode = m_mode; e.fc = m_fc;
    end
    sbq.push_back(e);
  endtask

  // One frame boundary: leave the origin, then enter it, then one tick cycle.
  task automatic frame(input int ms);
    step(0, 1, 1, ms);
    step(0, 0, 0, ms);
    step(0, 2, 3, ms);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        if (color !== 16'(e.color) || frame_tick !== 1'(e.tick) ||
            mode_active !== 2'(e.mode) || frame_count !== 8'(e.fc)) begin
          miscompares++;
          $display("FAIL vec%0d: got color=%h tick=%b mode=%0d fc=%0d, want color=%h tick=%0d mode=%0d fc=%0d",
                   vectors, color, frame_tick, mode_active, frame_count,
                   16'(e.color), e.tick, e.mode, e.fc);
        end
      end
    end
  end

  initial begin : driver
    int cx, cy, ms;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    // Checker corners.
    step(0, 8, 0, 0);
    step(0, 8, 8, 0);
    // Frame start, then hold the origin.
    step(0, 127, 159, 0);
    repeat (6) step(0, 0, 0, 0);
    // Mode change mid-frame takes effect on next tick.
    step(0, 40, 20, 1);
    step(0, 96, 3, 1);
    frame(1);
    step(0, 96, 3, 1);
    // Gradient corner.
    frame(2);
    step(0, 127, 159, 2);
    // Scroll mode across several frames.
    frame(3);
    for (int i = 0; i < 8; i++) begin
      frame(3);
      step(0, 4, 0, 3);
      step(0, 12, 9, 3);
    end
    frame(0);
    step(0, 4, 0, 0);
    // Frame counter wrap.
    for (int i = 0; i < 260; i++) frame(i % 4);
    // Reset in the middle of a scan.
    step(0, 50, 60, 2);
    step(1, 51, 60, 2);
    step(0, 0, 0, 2);
    step(0, 5, 5, 2);
    // Random traffic.
    cx = 0; cy = 0; ms = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) ms = $urandom_range(0, 3);
      case ($urandom_range(0, 7))
        0, 1: begin cx = 0; cy = 0; end
        2, 3: ;
        default: begin cx = $urandom_range(0, (1 << XB) - 1); cy = $urandom_range(0, (1 << YB) - 1); end
      endcase
      step($urandom_range(0, 299) == 0, cx, cy, ms);
    end
    @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
